sha256_msg_padder: RTL

Message padder and block builder for the SHA-256 datapath. It accepts the raw message as a stream of big-endian 32-bit words and appends the 0x80 marker, zero fill and the 64-bit bit-length. It emits complete 512-bit blocks in the exact layout the message-schedule expansion loads on `init`. It sits between the host/stream interface and the schedule/compression stage, as the producer end of the block interface.

---
 rtl/sha256_pkg.sv | 20 ++
 rtl/sha256_pad_word.sv | 20 ++
 rtl/sha256_msg_padder.sv | 120 ++++++++++++
 3 files changed

// File: rtl/sha256_pkg.sv
// sha256_pkg: shared types and constants for the SHA-256 message padder.
package sha256_pkg;

    typedef enum logic [1:0] {
        FILL,
        FINISH,
        OUT
    } pad_state_t;

    localparam int          SHA256_BLOCK_WORDS = 16;
    localparam int          SHA256_LEN_HI_IDX  = 14;
    localparam int          SHA256_LEN_LO_IDX  = 15;
    localparam logic [31:0] SHA256_PAD_WORD    = 32'h8000_0000;

    // Bit count contributed by a word carrying nbytes message bytes
    function automatic logic [63:0] bits_of(input logic [2:0] nbytes);
        return {58'd0, nbytes, 3'b000};
    endfunction

endpackage

// File: rtl/sha256_pad_word.sv
// sha256_pad_word: masks a final message word and inserts the 0x80 marker after its last byte.
module sha256_pad_word
    import sha256_pkg::*;
(
    input  logic [31:0] data,
    input  logic [2:0]  n,
    output logic [31:0] word,
    output logic        placed
);

    logic [31:0] keep;

    // Keep the first n bytes; a full word (n>=4) leaves the marker for a later slot
    always_comb begin
        placed = n < 3'd4;
        keep   = ~(32'hFFFF_FFFF >> {n, 3'b000});
        word   = (data & keep) | (placed ? SHA256_PAD_WORD >> {n, 3'b000} : 32'd0);
    end

endmodule

// File: rtl/sha256_msg_padder.sv
// sha256_msg_padder: packs a big-endian word stream into padded 512-bit SHA-256 blocks.
// Define SHA256_PAD_LEN_OUT_EN to add the registered msg_len output.
module sha256_msg_padder
    import sha256_pkg::*;
(
    input  logic         clk,
    input  logic         Reset,
    input  logic [31:0]  in_data,
    input  logic         in_valid,
    input  logic         in_last,
    input  logic [2:0]   in_bytes,
    output logic         in_ready,
    output logic [511:0] blk_data,
    output logic         blk_valid,
    output logic         blk_last,
`ifdef SHA256_PAD_LEN_OUT_EN
    output logic [63:0]  msg_len,
`endif
    input  logic         blk_ready
);

    pad_state_t                          state;
    logic [SHA256_BLOCK_WORDS-1:0][31:0] words;
    logic [3:0]                          widx;
    logic [63:0]                         len;
    logic                                pend80;
    logic                                pendlen;
    logic [31:0]                         pad_word;
    logic                                placed;
    logic [2:0]                          nbytes;
    logic                                len_fits;

    sha256_pad_word u_pad_word (
        .data   (in_data),
        .n      (in_bytes),
        .word   (pad_word),
        .placed (placed)
    );

    assign blk_data = words;

    // Bytes carried by the current input word and whether the length still fits this block
    always_comb begin
        nbytes   = !in_last ? 3'd4 : (in_bytes > 3'd4 ? 3'd4 : in_bytes);
        len_fits = pend80 ? (widx < 4'(SHA256_LEN_HI_IDX)) : (widx <= 4'(SHA256_LEN_HI_IDX));
    end

    // Block-building FSM: collect words, finish the padding, then hold the block for the consumer
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state     <= FILL;
            in_ready  <= 1'b1;
            blk_valid <= 1'b0;
            blk_last  <= 1'b0;
            words     <= '0;
            widx      <= '0;
            len       <= '0;
            pend80    <= 1'b0;
            pendlen   <= 1'b0;
`ifdef SHA256_PAD_LEN_OUT_EN
            msg_len   <= '0;
`endif
        end else begin
            case (state)
                FILL: if (in_valid) begin
                    words[widx] <= in_last ? pad_word : in_data;
                    widx        <= widx + 4'd1;
                    len         <= len + bits_of(nbytes);
                    pend80      <= in_last && !placed;
                    if (widx == 4'(SHA256_BLOCK_WORDS - 1)) begin
                        state     <= OUT;
                        in_ready  <= 1'b0;
                        blk_valid <= 1'b1;
                        blk_last  <= 1'b0;
                        pendlen   <= in_last && placed;
                    end else if (in_last) begin
                        state    <= FINISH;
                        in_ready <= 1'b0;
                    end
                end
                FINISH: begin
                    for (int i = 0; i < SHA256_BLOCK_WORDS; i++)
                        if (i >= int'(widx)) words[i] <= '0;
                    if (pend80) words[widx] <= SHA256_PAD_WORD;
                    if (len_fits) begin
                        words[SHA256_LEN_HI_IDX] <= len[63:32];
                        words[SHA256_LEN_LO_IDX] <= len[31:0];
`ifdef SHA256_PAD_LEN_OUT_EN
                        msg_len <= len;
`endif
                    end
                    blk_last  <= len_fits;
                    pendlen   <= !len_fits;
                    pend80    <= 1'b0;
                    state     <= OUT;
                    blk_valid <= 1'b1;
                end
                OUT: if (blk_ready) begin
                    words     <= '0;
                    widx      <= '0;
                    blk_valid <= 1'b0;
                    blk_last  <= 1'b0;
                    if (blk_last) len <= '0;
                    if (pend80 || pendlen) begin
                        state <= FINISH;
                    end else begin
                        state    <= FILL;
                        in_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= FILL;
                    in_ready  <= 1'b1;
                    blk_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
